mc_control_v2: RTL and testbench

MC_CONTROL_V2 -- requirements
Module: mc_control_v2

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_ctrl_decode.sv | 100 ++++++++++
 rtl/mc_control_v2.sv | 110 +++++++++++
 tb/tb_mc_control_v2.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state encoding, opcodes and ALU codes for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, RTEND, BRANCH, IEXEC, IEND, JUMP
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    CLS_LW, CLS_SW, CLS_R, CLS_BEQ, CLS_BNE,
    CLS_ADDI, CLS_ANDI, CLS_ORI, CLS_J, CLS_ILL
  } op_class_e;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;

  // Width-independent part of the control word; ALUOp travels separately.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state/opcode/ready to control-word decoder
module mc_ctrl_decode
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  state_e             state_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic               ready_i,
  output ctrl_t              ctrl_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output op_class_e          op_class_o
);

  // Classify the opcode; anything unlisted is illegal.
  always_comb begin
    op_class_o = CLS_ILL;
    case (op_i)
      OP_W'(OP_LW):   op_class_o = CLS_LW;
      OP_W'(OP_SW):   op_class_o = CLS_SW;
      OP_W'(OP_R):    op_class_o = CLS_R;
      OP_W'(OP_BEQ):  op_class_o = CLS_BEQ;
      OP_W'(OP_BNE):  op_class_o = CLS_BNE;
      OP_W'(OP_ADDI): op_class_o = CLS_ADDI;
      OP_W'(OP_ANDI): op_class_o = CLS_ANDI;
      OP_W'(OP_ORI):  op_class_o = CLS_ORI;
      OP_W'(OP_J):    op_class_o = CLS_J;
      default:        op_class_o = CLS_ILL;
    endcase
  end

  // Per-state control word; every field not named for a state stays zero.
  always_comb begin
    ctrl_o   = '0;
    alu_op_o = ALUOP_W'(ALU_ADD);
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.ir_write  = ready_i;
        ctrl_o.pc_write  = ready_i;
      end
      DECODE: begin
        ctrl_o.alu_src_b  = 2'b11;
        ctrl_o.instr_done = (op_class_o == CLS_ILL);
      end
      MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
      end
      MEMRD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.memto_reg  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = ready_i;
      end
      EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        alu_op_o         = ALUOP_W'(ALU_FUNCT);
      end
      RTEND: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 2'b01;
        ctrl_o.instr_done    = 1'b1;
        alu_op_o             = ALUOP_W'(ALU_SUB);
      end
      IEXEC, IEND: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = 2'b10;
        ctrl_o.reg_write  = (state_i == IEND);
        ctrl_o.instr_done = (state_i == IEND);
        if (op_class_o == CLS_ANDI)     alu_op_o = ALUOP_W'(ALU_AND);
        else if (op_class_o == CLS_ORI) alu_op_o = ALUOP_W'(ALU_OR);
        else                            alu_op_o = ALUOP_W'(ALU_ADD);
      end
      JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = 2'b10;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_v2.sv
// rtl/mc_control_v2.sv - multicycle datapath controller with memory wait and illegal-op flag
module mc_control_v2
  import mc_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3,
  parameter int MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               PCSel,
  output logic               instr_done,
  output logic               illegal_op
);

  state_e    state_q, state_d;
  logic      illegal_q, illegal_d;
  logic      is_bne_q, is_bne_d;
  logic      ready;
  ctrl_t     ctrl;
  op_class_e op_class;

  assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  mc_ctrl_decode #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .state_i    (state_q),
    .op_i       (Op),
    .ready_i    (ready),
    .ctrl_o     (ctrl),
    .alu_op_o   (ALUOp),
    .op_class_o (op_class)
  );

  // State, sticky illegal flag and latched branch polarity; reset acts without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      is_bne_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      is_bne_q  <= is_bne_d;
    end
  end

  // Next-state sequencing; Op is only consulted in DECODE and MEMADR here.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    is_bne_d  = is_bne_q;
    case (state_q)
      FETCH:  if (ready) state_d = DECODE;
      DECODE: begin
        is_bne_d = (op_class == CLS_BNE);
        case (op_class)
          CLS_LW, CLS_SW:               state_d = MEMADR;
          CLS_R:                        state_d = EXEC;
          CLS_BEQ, CLS_BNE:             state_d = BRANCH;
          CLS_ADDI, CLS_ANDI, CLS_ORI:  state_d = IEXEC;
          CLS_J:                        state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op_class == CLS_LW) ? MEMRD : MEMWR;
      MEMRD:  if (ready) state_d = MEMWB;
      MEMWR:  if (ready) state_d = FETCH;
      EXEC:   state_d = RTEND;
      IEXEC:  state_d = IEND;
      MEMWB, RTEND, IEND, BRANCH, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Strobes that could write state are held off while reset is low.
  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemtoReg   = ctrl.memto_reg;
  assign RegDst     = ctrl.reg_dst;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign PCSource   = ctrl.pc_source;
  assign MemWrite   = reset & ctrl.mem_write;
  assign IRWrite    = reset & ctrl.ir_write;
  assign RegWrite   = reset & ctrl.reg_write;
  assign instr_done = reset & ctrl.instr_done;
  assign PCSel      = reset & (ctrl.pc_write | (ctrl.pc_write_cond & (Zero ^ is_bne_q)));
  assign illegal_op = illegal_q | ((state_q == DECODE) && (op_class == CLS_ILL));

endmodule

// File: tb/tb_mc_control_v2.sv
// tb/tb_mc_control_v2.sv - directed self-checking bench for mc_control_v2
module tb_mc_control_v2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       PCSel, instr_done, illegal_op;

  int vectors = 0;
  int fails   = 0;

  mc_control_v2 dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .PCSel      (PCSel),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; Op = 6'b000000; Zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_irwrite",  8'(IRWrite),    8'd0);
    chk("rst_pcsel",    8'(PCSel),      8'd0);
    chk("rst_regwrite", 8'(RegWrite),   8'd0);
    chk("rst_memwrite", 8'(MemWrite),   8'd0);
    chk("rst_done",     8'(instr_done), 8'd0);
    chk("rst_illegal",  8'(illegal_op), 8'd0);
    step(); step();
    reset = 1'b1; #1;

    // lw, memory always ready: FETCH DECODE MEMADR MEMRD MEMWB
    Op = 6'b100011; #1;
    chk("lw_c1_irwrite", 8'(IRWrite), 8'd1);
    chk("lw_c1_pcsel",   8'(PCSel),   8'd1);
    chk("lw_c1_memread", 8'(MemRead), 8'd1);
    chk("lw_c1_srcb",    8'(ALUSrcB), 8'd1);
    chk("lw_c1_done",    8'(instr_done), 8'd0);
    step();
    chk("lw_c2_srcb",    8'(ALUSrcB), 8'd3);
    chk("lw_c2_memread", 8'(MemRead), 8'd0);
    chk("lw_c2_done",    8'(instr_done), 8'd0);
    step();
    chk("lw_c3_srca",    8'(ALUSrcA), 8'd1);
    chk("lw_c3_srcb",    8'(ALUSrcB), 8'd2);
    step();
    chk("lw_c4_iord",    8'(IorD),    8'd1);
    chk("lw_c4_memread", 8'(MemRead), 8'd1);
    chk("lw_c4_done",    8'(instr_done), 8'd0);
    step();
    chk("lw_c5_regwrite", 8'(RegWrite), 8'd1);
    chk("lw_c5_memtoreg", 8'(MemtoReg), 8'd1);
    chk("lw_c5_regdst",   8'(RegDst),   8'd0);
    chk("lw_c5_done",     8'(instr_done), 8'd1);
    step();
    chk("lw_back_irwrite", 8'(IRWrite), 8'd1);
    chk("lw_back_done",    8'(instr_done), 8'd0);

    // fetch stalls while memory is not ready
    mem_ready = 1'b0; #1;
    chk("fstall_irwrite", 8'(IRWrite), 8'd0);
    chk("fstall_pcsel",   8'(PCSel),   8'd0);
    step();
    chk("fstall_memread", 8'(MemRead), 8'd1);
    chk("fstall_srcb",    8'(ALUSrcB), 8'd1);
    mem_ready = 1'b1; Op = 6'b101011; #1;
    chk("sw_c1_irwrite", 8'(IRWrite), 8'd1);

    // sw with three wait cycles in MEMWR
    step();
    step();
    chk("sw_memadr_srcb", 8'(ALUSrcB), 8'd2);
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_wait_memwrite", 8'(MemWrite),   8'd1);
      chk("sw_wait_iord",     8'(IorD),       8'd1);
      chk("sw_wait_done",     8'(instr_done), 8'd0);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("sw_acc_memwrite", 8'(MemWrite),   8'd1);
    chk("sw_acc_done",     8'(instr_done), 8'd1);
    step();
    chk("sw_back_memwrite", 8'(MemWrite), 8'd0);
    chk("sw_back_irwrite",  8'(IRWrite),  8'd1);
    chk("sw_back_done",     8'(instr_done), 8'd0);

    // bne with Zero=0 is taken
    Op = 6'b000101; Zero = 1'b0;
    step(); step();
    chk("bne_pcsel",  8'(PCSel),      8'd1);
    chk("bne_pcsrc",  8'(PCSource),   8'd1);
    chk("bne_aluop",  8'(ALUOp),      8'd1);
    chk("bne_done",   8'(instr_done), 8'd1);
    step();

    // beq with Zero=0 not taken, Zero=1 taken
    Op = 6'b000100;
    step(); step();
    chk("beq_z0_pcsel", 8'(PCSel), 8'd0);
    chk("beq_done",     8'(instr_done), 8'd1);
    Zero = 1'b1; #1;
    chk("beq_z1_pcsel", 8'(PCSel), 8'd1);
    Zero = 1'b0;
    step();

    // ori: ALUOp=4 in IEXEC and IEND, RegWrite only in IEND
    Op = 6'b001101;
    step(); step();
    chk("ori_iexec_aluop",    8'(ALUOp),    8'd4);
    chk("ori_iexec_regwrite", 8'(RegWrite), 8'd0);
    chk("ori_iexec_srcb",     8'(ALUSrcB),  8'd2);
    step();
    chk("ori_iend_aluop",    8'(ALUOp),      8'd4);
    chk("ori_iend_regwrite", 8'(RegWrite),   8'd1);
    chk("ori_iend_regdst",   8'(RegDst),     8'd0);
    chk("ori_iend_done",     8'(instr_done), 8'd1);
    step();

    // j completes in cycle 3
    Op = 6'b000010;
    step(); step();
    chk("j_pcsrc", 8'(PCSource),   8'd2);
    chk("j_pcsel", 8'(PCSel),      8'd1);
    chk("j_done",  8'(instr_done), 8'd1);
    step();

    // illegal opcode sets the sticky flag in DECODE
    Op = 6'b111111; #1;
    chk("ill_fetch_flag", 8'(illegal_op), 8'd0);
    step();
    chk("ill_dec_flag", 8'(illegal_op), 8'd1);
    chk("ill_dec_done", 8'(instr_done), 8'd1);
    step();
    chk("ill_fetch_irwrite", 8'(IRWrite), 8'd1);
    chk("ill_sticky1",       8'(illegal_op), 8'd1);

    // R-type afterwards; flag stays set
    Op = 6'b000000;
    step(); step();
    chk("r_exec_aluop", 8'(ALUOp),   8'd2);
    chk("r_exec_srca",  8'(ALUSrcA), 8'd1);
    step();
    chk("r_rtend_regdst",   8'(RegDst),     8'd1);
    chk("r_rtend_regwrite", 8'(RegWrite),   8'd1);
    chk("r_rtend_done",     8'(instr_done), 8'd1);
    chk("ill_sticky2",      8'(illegal_op), 8'd1);
    step();

    // asynchronous reset during MEMRD
    Op = 6'b100011;
    step(); step(); step();
    mem_ready = 1'b0; #1;
    chk("ar_memrd_iord", 8'(IorD), 8'd1);
    mem_ready = 1'b1; reset = 1'b0; #1;
    chk("ar_iord",     8'(IorD),       8'd0);
    chk("ar_memread",  8'(MemRead),    8'd1);
    chk("ar_irwrite",  8'(IRWrite),    8'd0);
    chk("ar_pcsel",    8'(PCSel),      8'd0);
    chk("ar_regwrite", 8'(RegWrite),   8'd0);
    chk("ar_done",     8'(instr_done), 8'd0);
    chk("ar_illegal",  8'(illegal_op), 8'd0);
    step();
    chk("ar_hold_regwrite", 8'(RegWrite), 8'd0);
    chk("ar_hold_irwrite",  8'(IRWrite),  8'd0);
    reset = 1'b1; #1;
    chk("rel_irwrite",  8'(IRWrite),  8'd1);
    chk("rel_regwrite", 8'(RegWrite), 8'd0);
    chk("rel_iord",     8'(IorD),     8'd0);

    // addi after release: normal sequencing
    Op = 6'b001000;
    step(); step();
    chk("addi_iexec_aluop", 8'(ALUOp),   8'd0);
    chk("addi_iexec_srcb",  8'(ALUSrcB), 8'd2);
    step();
    chk("addi_iend_regwrite", 8'(RegWrite),   8'd1);
    chk("addi_iend_done",     8'(instr_done), 8'd1);
    chk("addi_illegal",       8'(illegal_op), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
